// File: rtl/stream_max_pool.sv
// stream_max_pool: streaming XxY max pooler (stride = window) over an IMG_W x IMG_H frame.
// Latency: a pooled result is registered one cycle after the last pixel of its window is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result blocks input and holds all counters.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_ready      - pixel handshake, in_data carries a DEPTH-bit pixel in raster order
//   out_valid/out_ready    - result handshake, out_data is the window maximum
//   out_last               - marks the final pooled result of a frame
//
// Build option: define MAXPOOL_SIGNED_EN to compare pixels as two's-complement values;
// otherwise pixels are compared unsigned.

module stream_max_pool #(
  parameter int DEPTH = 8,
  parameter int X     = 3,
  parameter int Y     = 3,
  parameter int IMG_W = 12,
  parameter int IMG_H = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEPTH-1:0] out_data,
  output logic             out_last
);

  // Windows per row / per column of the frame.
  localparam int OW = IMG_W / X;
  localparam int OH = IMG_H / Y;

  // Counter widths, never narrower than one bit.
  localparam int CXW = (X  > 1) ? $clog2(X)  : 1;
  localparam int OXW = (OW > 1) ? $clog2(OW) : 1;
  localparam int CYW = (Y  > 1) ? $clog2(Y)  : 1;
  localparam int OYW = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [CXW-1:0] CX_MAX = CXW'(X - 1);
  localparam logic [OXW-1:0] OX_MAX = OXW'(OW - 1);
  localparam logic [CYW-1:0] CY_MAX = CYW'(Y - 1);
  localparam logic [OYW-1:0] OY_MAX = OYW'(OH - 1);

  // Geometry must tile exactly; anything else is rejected at elaboration.
  generate
    if (X < 1 || Y < 1) begin : g_bad_window
      $error("stream_max_pool: X and Y must be at least 1");
    end
    if (IMG_W % X != 0) begin : g_bad_width
      $error("stream_max_pool: IMG_W must be a multiple of X");
    end
    if (IMG_H % Y != 0) begin : g_bad_height
      $error("stream_max_pool: IMG_H must be a multiple of Y");
    end
  endgenerate

  // Position of the current pixel: column inside window, window column,
  // row inside window, window row.
  logic [CXW-1:0] cx;
  logic [OXW-1:0] ox;
  logic [CYW-1:0] cy;
  logic [OYW-1:0] oy;

  // One partial maximum per window column. Not reset: the first pixel of
  // every window overwrites its entry, so stale contents never leak out.
  logic [DEPTH-1:0] col_buf [OW];

  logic             accept;
  logic             cx_end;
  logic             ox_end;
  logic             cy_end;
  logic             oy_end;
  logic             win_start;
  logic             win_done;
  logic             newer;
  logic [DEPTH-1:0] stored;
  logic [DEPTH-1:0] acc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign cx_end = (cx == CX_MAX);
  assign ox_end = (ox == OX_MAX);
  assign cy_end = (cy == CY_MAX);
  assign oy_end = (oy == OY_MAX);

  assign win_start = (cx == '0) && (cy == '0);
  assign win_done  = cx_end && cy_end;

  assign stored = col_buf[ox];

  // Strictly-greater test: on ties the stored value is retained.
`ifdef MAXPOOL_SIGNED_EN
  assign newer = $signed(in_data) > $signed(stored);
`else
  assign newer = in_data > stored;
`endif

  always_comb begin
    acc = stored;
    if (win_start || newer) begin
      acc = in_data;
    end
  end

  // Nested raster counters: cx -> ox -> cy -> oy, all wrapping at frame end
  // so the next pixel starts a new frame with no idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= '0;
      ox <= '0;
      cy <= '0;
      oy <= '0;
    end else if (accept) begin
      if (!cx_end) begin
        cx <= cx + 1'b1;
      end else begin
        cx <= '0;
        if (!ox_end) begin
          ox <= ox + 1'b1;
        end else begin
          ox <= '0;
          if (!cy_end) begin
            cy <= cy + 1'b1;
          end else begin
            cy <= '0;
            if (!oy_end) begin
              oy <= oy + 1'b1;
            end else begin
              oy <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      col_buf[ox] <= acc;
    end
  end

  // Single output register. A new window can only complete while in_ready is
  // high, i.e. when the register is empty or being drained this same cycle,
  // so loading never overwrites an untaken result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && win_done) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_last  <= ox_end && oy_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_max_pool.sv
module tb_stream_max_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default geometry instance (3x3 windows over 12x12)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [7:0] a_in_data, a_out_data;

  // Small geometry instance (2x2 windows over 4x2)
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0] b_in_data, b_out_data;

  stream_max_pool #(.DEPTH(8), .X(3), .Y(3), .IMG_W(12), .IMG_H(12)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  stream_max_pool #(.DEPTH(8), .X(2), .Y(2), .IMG_W(4), .IMG_H(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int a_src[$];
  int a_sent[$];
  int a_od[$];
  int a_ol[$];
  int a_acc_cyc[$];
  int a_first_vld;
  int b_src[$];
  int b_od[$];
  int b_ol[$];

  logic       s_valid, s_ready;
  logic [7:0] s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Larger of two pixels under the build's ordering.
  function automatic int pmax(input int a, input int b);
    int sa, sb;
    sa = a;
    sb = b;
`ifdef MAXPOOL_SIGNED_EN
    if (sa > 127) sa -= 256;
    if (sb > 127) sb -= 256;
`endif
    return (sb > sa) ? b : a;
  endfunction

  // One cycle on instance A: drive at negedge, sample 1ns later.
  task automatic a_cycle(input bit vld, input bit rdy);
    @(negedge clk);
    a_in_valid  = vld && (a_src.size() > 0);
    a_in_data   = (a_src.size() > 0) ? 8'(a_src[0]) : 8'h00;
    a_out_ready = rdy;
    #1;
    s_valid = a_out_valid;
    s_ready = a_in_ready;
    s_data  = a_out_data;
    if (a_out_valid && a_first_vld < 0) a_first_vld = cyc;
    if (a_out_valid && a_out_ready) begin
      a_od.push_back(int'(a_out_data));
      a_ol.push_back(int'(a_out_last));
    end
    if (a_in_valid && a_in_ready) begin
      a_sent.push_back(a_src.pop_front());
      a_acc_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic b_cycle(input bit vld, input bit rdy);
    @(negedge clk);
    b_in_valid  = vld && (b_src.size() > 0);
    b_in_data   = (b_src.size() > 0) ? 8'(b_src[0]) : 8'h00;
    b_out_ready = rdy;
    #1;
    if (b_out_valid && b_out_ready) begin
      b_od.push_back(int'(b_out_data));
      b_ol.push_back(int'(b_out_last));
    end
    if (b_in_valid && b_in_ready) void'(b_src.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a_src.delete(); a_sent.delete(); a_od.delete(); a_ol.delete(); a_acc_cyc.delete();
    b_src.delete(); b_od.delete(); b_ol.delete();
    a_first_vld = -1;
  endtask

  task automatic a_run(input string tag, input int vld_pct, input int rdy_pct);
    for (int i = 0; i < 20000 && a_src.size() > 0; i++)
      a_cycle($urandom_range(99) < vld_pct, $urandom_range(99) < rdy_pct);
    for (int i = 0; i < 50; i++) a_cycle(1'b0, 1'b1);
    check({tag, "_drained"}, a_src.size(), 0);
  endtask

  // Reference: per frame of 144 pixels, the maximum over each 3x3 tile,
  // tiles in raster order, last flag on the bottom-right tile.
  task automatic a_compare(input string tag);
    int ed[$];
    int el[$];
    int m;
    for (int f = 0; f < a_sent.size() / 144; f++)
      for (int wy = 0; wy < 4; wy++)
        for (int wx = 0; wx < 4; wx++) begin
          m = a_sent[f*144 + wy*36 + wx*3];
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              m = pmax(m, a_sent[f*144 + (wy*3 + r)*12 + wx*3 + c]);
          ed.push_back(m);
          el.push_back((wx == 3 && wy == 3) ? 1 : 0);
        end
    check({tag, "_count"}, a_od.size(), ed.size());
    for (int i = 0; i < ed.size() && i < a_od.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), a_od[i], ed[i]);
      check($sformatf("%s_last%0d", tag, i), a_ol[i], el[i]);
    end
  endtask

  task automatic b_run();
    for (int i = 0; i < 100 && b_src.size() > 0; i++) b_cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) b_cycle(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
    a_first_vld = -1;
    repeat (2) @(negedge clk);
    do_reset();

    // Reset state
    #1;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_last", a_out_last, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_in_ready", b_in_ready, 1);

    // Ramp frame: results 26,29,32,35,62,...,143
    for (int i = 0; i < 144; i++) a_src.push_back(i);
    a_run("ramp", 100, 100);
    a_compare("ramp");
    check("ramp_first_result", a_od[0], 26);
    check("ramp_latency", a_first_vld, a_acc_cyc[26] + 1);

    // Backpressure after the first result
    do_reset();
    for (int i = 0; i < 144; i++) a_src.push_back(i);
    for (int i = 0; i < 200 && a_sent.size() < 27; i++) a_cycle(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      a_cycle(1'b1, 1'b0);
      check($sformatf("bp_valid%0d", k), s_valid, 1);
      check($sformatf("bp_data%0d", k), s_data, 26);
      check($sformatf("bp_in_ready%0d", k), s_ready, 0);
    end
    check("bp_no_accept", a_sent.size(), 27);
    a_run("bp", 100, 100);
    a_compare("bp");

    // Window-max position on the 4x2 frame
    do_reset();
    b_src = '{5, 1, 0, 9, 3, 7, 2, 4};
    b_run();
    check("pos_count", b_od.size(), 2);
    check("pos_data0", b_od[0], 7);
    check("pos_last0", b_ol[0], 0);
    check("pos_data1", b_od[1], 9);
    check("pos_last1", b_ol[1], 1);

    // Signedness
    do_reset();
    b_src = '{255, 1, 0, 0, 0, 0, 0, 0};
    b_run();
    check("sign_count", b_od.size(), 2);
`ifdef MAXPOOL_SIGNED_EN
    check("sign_data0", b_od[0], 1);
`else
    check("sign_data0", b_od[0], 255);
`endif
    check("sign_data1", b_od[1], 0);
    check("sign_last1", b_ol[1], 1);

    // Reset mid-frame after 40 pixels
    do_reset();
    for (int i = 0; i < 144; i++) a_src.push_back(i);
    for (int i = 0; i < 200 && a_sent.size() < 40; i++) a_cycle(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_out_last", a_out_last, 0);
    check("midrst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    a_src.delete(); a_sent.delete(); a_od.delete(); a_ol.delete(); a_acc_cyc.delete();
    for (int i = 0; i < 144; i++) a_src.push_back(int'($urandom_range(255)));
    a_run("midrst", 100, 100);
    a_compare("midrst");

    // Three back-to-back random frames with random gaps on both sides
    do_reset();
    for (int i = 0; i < 3 * 144; i++) a_src.push_back(int'($urandom_range(255)));
    a_run("rand", 70, 70);
    a_compare("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
